rv_word_serializer: RTL

- Ready/valid transmitter that sits upstream of the stream register slices and narrow-stream sinks.
- Accepts one wide word of up to NUM_BEATS beats per handshake and emits it as a sequence of DATA_WIDTH beats, LSB beat first, marking the final beat with last_out.
- Sustains full throughput: the next word is accepted in the same cycle the last beat of the current word is accepted.

---
 rtl/rv_word_serializer.sv | 84 ++++++++
 1 files changed

// File: rtl/rv_word_serializer.sv
// rv_word_serializer: takes one wide word per ready/valid handshake and
// emits it as DATA_WIDTH beats, least-significant beat first, with last_out
// on the final beat. A new word can be taken in the same cycle the final
// beat of the previous one leaves, so back-to-back words stream gap-free.
module rv_word_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BEATS  = 4,
  parameter int LEN_W      = $clog2(NUM_BEATS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [NUM_BEATS*DATA_WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0]                len_in,
  output logic                            ready_out,
  output logic                            valid_out,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            last_out,
  input  logic                            ready_in
);

  localparam int WORD_W = NUM_BEATS * DATA_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_reg,    state_next;
  logic [WORD_W-1:0]  shift_reg,    shift_next;
  logic [LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [LEN_W-1:0]   last_idx_reg, last_idx_next;

  logic beat_accept;
  logic word_accept;

  // Output view of the current beat; ready_out depends combinationally on
  // ready_in so the next word can slip in on the final beat accept.
  always_comb begin
    valid_out   = (state_reg == SEND);
    last_out    = valid_out & (beat_cnt_reg == last_idx_reg);
    data_out    = shift_reg[DATA_WIDTH-1:0];
    beat_accept = valid_out & ready_in;
    ready_out   = (state_reg == IDLE) | (beat_accept & last_out);
    word_accept = valid_in & ready_out;
  end

  // Next-state logic: load on word accept, shift on non-final beat accept,
  // drain to IDLE (clearing leftover data) when the word completes.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    beat_cnt_next = beat_cnt_reg;
    last_idx_next = last_idx_reg;
    if (word_accept) begin
      state_next    = SEND;
      shift_next    = data_in;
      beat_cnt_next = '0;
      last_idx_next = len_in;
    end else if (beat_accept) begin
      if (last_out) begin
        state_next    = IDLE;
        shift_next    = '0;
        beat_cnt_next = '0;
      end else begin
        shift_next    = {{DATA_WIDTH{1'b0}}, shift_reg[WORD_W-1:DATA_WIDTH]};
        beat_cnt_next = beat_cnt_reg + LEN_W'(1);
      end
    end
  end

  // State registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      beat_cnt_reg <= '0;
      last_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      beat_cnt_reg <= beat_cnt_next;
      last_idx_reg <= last_idx_next;
    end
  end

endmodule
